// File: rtl/aes_round_engine.sv
// aes_round_engine
// Iterative AES encryption core that performs one full cipher round per clock.
// The 128-bit state register feeds the S-box layer, then ShiftRows, MixColumns
// and AddRoundKey. The result is written back into the state register. The
// last round skips MixColumns and writes the ciphertext output register.
//
// Byte i of any 128-bit block sits in bits [127-8i -: 8] and maps to
// row i%4, column i/4 (column-major order).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request to encrypt plaintext; sampled only while busy=0
//   plaintext  input block, captured when start is accepted
//   rk_idx     round-key index requested this cycle (equals round counter)
//   round_key  round key for rk_idx, supplied combinationally by an external store
//   ciphertext registered result; holds its value until the next completion
//   busy       high while a block is in flight
//   done       one-cycle pulse when ciphertext updates
module aes_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box. Entry b is stored at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Output byte at (row, col) takes the input byte at (row, (col+row) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            r[103-32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_t          fsm_r;
    fsm_t          fsm_next_s;
    logic [127:0]  state_r;
    logic [127:0]  state_next_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_next_s;
    logic [127:0]  ciphertext_r;
    logic [127:0]  ciphertext_next_s;
    logic          busy_r;
    logic          busy_next_s;
    logic          done_r;
    logic          done_next_s;
    logic [127:0]  shifted_s;
    logic [127:0]  mid_round_s;
    logic [127:0]  final_round_s;

    // Round datapath: S-box layer, ShiftRows, then the two AddRoundKey variants.
    always_comb begin
        shifted_s     = shift_rows(sub_bytes(state_r));
        mid_round_s   = mix_columns(shifted_s) ^ round_key;
        final_round_s = shifted_s ^ round_key;
    end

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        fsm_next_s        = fsm_r;
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        ciphertext_next_s = ciphertext_r;
        busy_next_s       = busy_r;
        done_next_s       = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (start) begin
                    // Initial AddRoundKey with key 0, which is requested while idle.
                    state_next_s = plaintext ^ round_key;
                    cnt_next_s   = 4'd1;
                    busy_next_s  = 1'b1;
                    fsm_next_s   = ST_RUN;
                end else begin
                    cnt_next_s  = 4'd0;
                    busy_next_s = 1'b0;
                    fsm_next_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_ROUND) begin
                    ciphertext_next_s = final_round_s;
                    done_next_s       = 1'b1;
                    busy_next_s       = 1'b0;
                    cnt_next_s        = 4'd0;
                    fsm_next_s        = ST_IDLE;
                end else begin
                    state_next_s = mid_round_s;
                    cnt_next_s   = cnt_r + 4'd1;
                    fsm_next_s   = ST_RUN;
                end
            end
            default: begin
                fsm_next_s  = ST_IDLE;
                cnt_next_s  = 4'd0;
                busy_next_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. Reset aborts any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r        <= ST_IDLE;
            state_r      <= 128'h0;
            cnt_r        <= 4'd0;
            ciphertext_r <= 128'h0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            fsm_r        <= fsm_next_s;
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            ciphertext_r <= ciphertext_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    assign rk_idx     = cnt_r;
    assign ciphertext = ciphertext_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_aes_round_engine.sv
// Testbench for aes_round_engine. A scoreboard queue holds the expected
// ciphertexts, and monitors compare them on every done pulse. Two instances
// are used: AES-128 (10 rounds) and AES-256 (14 rounds).
module tb_aes_round_engine;

    localparam logic [2047:0] SBOX_TB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ST_E0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ST_E1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         rst_n;
    logic         start_a;
    logic [127:0] plaintext_a;
    logic [3:0]   rk_idx_a;
    logic [127:0] round_key_a;
    logic [127:0] ciphertext_a;
    logic         busy_a;
    logic         done_a;
    logic         start_b;
    logic [127:0] plaintext_b;
    logic [3:0]   rk_idx_b;
    logic [127:0] round_key_b;
    logic [127:0] ciphertext_b;
    logic         busy_b;
    logic         done_b;

    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];
    logic [31:0]  w    [0:59];
    logic [127:0] q_a  [$];
    logic [127:0] q_b  [$];

    int n_total;
    int n_pass;
    int done_cnt_a;
    int done_cnt_b;

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .plaintext(plaintext_a),
        .rk_idx(rk_idx_a), .round_key(round_key_a), .ciphertext(ciphertext_a),
        .busy(busy_a), .done(done_a)
    );

    aes_round_engine #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .plaintext(plaintext_b),
        .rk_idx(rk_idx_b), .round_key(round_key_b), .ciphertext(ciphertext_b),
        .busy(busy_b), .done(done_b)
    );

    // The key-schedule store answers combinationally.
    assign round_key_a = rk_a[rk_idx_a];
    assign round_key_b = rk_b[rk_idx_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX_TB;
        return t[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    // Standard AES key expansion into w[0 .. 4*(nr+1)-1].
    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] temp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
    endtask

    task automatic load_key_a(input logic [127:0] k);
        expand({k, 128'h0}, 4, 10);
        for (int r = 0; r < 16; r++) rk_a[r] = 128'h0;
        for (int r = 0; r <= 10; r++) rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key_b(input logic [255:0] k);
        expand(k, 8, 14);
        for (int r = 0; r < 16; r++) rk_b[r] = 128'h0;
        for (int r = 0; r <= 14; r++) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Scoreboard monitor for the 10-round instance.
    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL done_a_unexpected: got done=1 with ciphertext %h, expected no pending block", ciphertext_a);
            end else begin
                check("ciphertext_a", ciphertext_a, q_a.pop_front());
            end
        end
    end

    // Scoreboard monitor for the 14-round instance.
    always @(negedge clk) begin
        if (done_b) begin
            done_cnt_b++;
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL done_b_unexpected: got done=1 with ciphertext %h, expected no pending block", ciphertext_b);
            end else begin
                check("ciphertext_b", ciphertext_b, q_b.pop_front());
            end
        end
    end

    // Run one block on the 10-round instance. The task is entered 1 time unit
    // after an edge, with the DUT idle or in its done cycle. abort_at=k pulls
    // reset after edge E(k-1).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct,
                             input logic [127:0] hold_ct, input int abort_at,
                             input bit spurious, input bit probe);
        bit aborted;
        aborted     = 1'b0;
        plaintext_a = pt;
        start_a     = 1'b1;
        check("rk_idx_at_start", rk_idx_a, 128'd0);
        q_a.push_back(exp_ct);
        @(posedge clk); #1;
        start_a     = 1'b0;
        plaintext_a = ~pt;
        for (int k = 1; k <= 10; k++) begin
            if (abort_at == k) begin
                rst_n = 1'b0;
                #1;
                q_a.delete();
                check("rst_ciphertext", ciphertext_a, 128'h0);
                check("rst_busy", busy_a, 128'd0);
                check("rst_done", done_a, 128'd0);
                check("rst_rk_idx", rk_idx_a, 128'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("rst_hold_done", done_a, 128'd0);
                    check("rst_hold_ciphertext", ciphertext_a, 128'h0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                check("post_rst_busy", busy_a, 128'd0);
                aborted = 1'b1;
                break;
            end
            check("rk_idx_run", rk_idx_a, 128'(k));
            check("busy_run", busy_a, 128'd1);
            check("done_run", done_a, 128'd0);
            check("ciphertext_hold", ciphertext_a, hold_ct);
            if (probe && k == 1) check("state_after_e0", dut.state_r, ST_E0);
            if (probe && k == 2) check("state_after_e1", dut.state_r, ST_E1);
            start_a = spurious && (k == 3 || k == 7);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        if (!aborted) begin
            check("done_at_last_edge", done_a, 128'd1);
            check("busy_at_done", busy_a, 128'd0);
            check("rk_idx_at_done", rk_idx_a, 128'd0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        int cnt_before;
        n_total     = 0;
        n_pass      = 0;
        done_cnt_a  = 0;
        done_cnt_b  = 0;
        start_a     = 1'b0;
        start_b     = 1'b0;
        plaintext_a = 128'h0;
        plaintext_b = 128'h0;
        load_key_a(KEY_B);
        load_key_b(KEY_C3);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ciphertext", ciphertext_a, 128'h0);
        check("reset_busy", busy_a, 128'd0);
        check("reset_done", done_a, 128'd0);
        check("reset_rk_idx", rk_idx_a, 128'd0);
        check("reset_ciphertext_b", ciphertext_b, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 App. B with state probes.
        run_block(PT_B, CT_B, 128'h0, 0, 1'b0, 1'b1);

        // App. C.1, started in the done cycle of the previous block.
        load_key_a(KEY_C1);
        run_block(PT_C, CT_C1, CT_B, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_low_after_pulse", done_a, 128'd0);
        check("ciphertext_held_idle", ciphertext_a, CT_C1);

        // Extra start pulses while busy must be ignored.
        load_key_a(KEY_B);
        cnt_before = done_cnt_a;
        run_block(PT_B, CT_B, CT_C1, 0, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check("done_low_idle", done_a, 128'd0);
        end
        check("single_done_pulse", 128'(done_cnt_a - cnt_before), 128'd1);

        // Reset in the middle of a block, then rerun the same vector.
        cnt_before = done_cnt_a;
        run_block(PT_B, CT_B, CT_B, 5, 1'b0, 1'b0);
        check("no_done_on_abort", 128'(done_cnt_a - cnt_before), 128'd0);
        run_block(PT_B, CT_B, 128'h0, 0, 1'b0, 1'b1);
        @(posedge clk); #1;

        // AES-256 on the 14-round instance (App. C.3).
        plaintext_b = PT_C;
        start_b     = 1'b1;
        q_b.push_back(CT_C3);
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            check("b_rk_idx", rk_idx_b, 128'(k));
            check("b_done_low", done_b, 128'd0);
            check("b_busy", busy_b, 128'd1);
            @(posedge clk); #1;
        end
        check("b_done_at_e14", done_b, 128'd1);
        check("b_busy_at_done", busy_b, 128'd0);

        // Drain: every pushed expectation must have been consumed.
        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("queue_a_drained", 128'(q_a.size()), 128'd0);
        check("queue_b_drained", 128'(q_b.size()), 128'd0);
        check("done_count_b", 128'(done_cnt_b), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
